// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data-cache controller: line geometry and FSM states.
package dcache_ctrl_pkg;

    localparam int LINEWORDS_FIXED = 4;
    localparam int WOFF_W          = 2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE_THRU = 2'd1,
        ST_REFILL     = 2'd2,
        ST_RESUME     = 2'd3
    } state_e;

endpackage

// File: rtl/dcache_ctrl_fill_counter.sv
// Word counter for line refills: sync clear, increment enable, terminal count at last word.
module dcache_ctrl_fill_counter
    import dcache_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [WOFF_W-1:0] cnt_o,
    output logic              tc_o
);

    logic [WOFF_W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; increment wraps naturally at the line end.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (inc_i) cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == {WOFF_W{1'b1}});

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller with read/miss stats.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int CNTWIDTH  = 16,
    parameter int LINEWORDS = 4
) (
    input  logic                Clk_i,
    input  logic                Reset_i,
    input  logic                CpuReq_i,
    input  logic                CpuWr_i,
    input  logic [WOFF_W-1:0]   CpuWordOff_i,
    input  logic                Match_i,
    input  logic                Valid_i,
    input  logic                MemAck_i,
    output logic                CpuReady_o,
    output logic                MemReq_o,
    output logic                MemWr_o,
    output logic [WOFF_W-1:0]   MemWordOff_o,
    output logic                DataWe_o,
    output logic [WOFF_W-1:0]   WordSel_o,
    output logic                FillSel_o,
    output logic                TagWe_o,
    output logic                ValidWe_o,
    output logic                ValidData_o,
    output logic [CNTWIDTH-1:0] ReadCnt_o,
    output logic [CNTWIDTH-1:0] MissCnt_o
);

    // The word-select datapath is hard-wired to a 4-word line.
    if (LINEWORDS != LINEWORDS_FIXED) begin : g_bad_linewords
        $error("dcache_ctrl: LINEWORDS must be 4");
    end

    state_e              state_q, state_d;
    logic [WOFF_W-1:0]   off_q, off_d;
    logic [CNTWIDTH-1:0] rd_q, rd_d, miss_q, miss_d;
    logic                fc_clr, fc_inc, fc_tc;
    logic [WOFF_W-1:0]   fc_cnt;
    logic                hit;

    assign hit = Valid_i & Match_i;

    dcache_ctrl_fill_counter u_fill (
        .clk_i (Clk_i),
        .rst_i (Reset_i),
        .clr_i (fc_clr),
        .inc_i (fc_inc),
        .cnt_o (fc_cnt),
        .tc_o  (fc_tc)
    );

    // Next-state, strobe and counter logic; everything is forced low while in reset.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        rd_d         = rd_q;
        miss_d       = miss_q;
        fc_clr       = 1'b0;
        fc_inc       = 1'b0;
        CpuReady_o   = 1'b0;
        MemReq_o     = 1'b0;
        MemWr_o      = 1'b0;
        MemWordOff_o = '0;
        DataWe_o     = 1'b0;
        WordSel_o    = '0;
        FillSel_o    = 1'b0;
        TagWe_o      = 1'b0;
        ValidWe_o    = 1'b0;
        ValidData_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (CpuReq_i && !CpuWr_i) begin
                    if (hit) begin
                        CpuReady_o = 1'b1;
                        WordSel_o  = CpuWordOff_i;
                        rd_d       = rd_q + 1'b1;
                    end else begin
                        // Invalidate first so an abandoned refill never leaves a stale line valid.
                        ValidWe_o = 1'b1;
                        fc_clr    = 1'b1;
                        miss_d    = miss_q + 1'b1;
                        state_d   = ST_REFILL;
                    end
                end else if (CpuReq_i && CpuWr_i) begin
                    if (hit) begin
                        DataWe_o  = 1'b1;
                        WordSel_o = CpuWordOff_i;
                    end
                    off_d   = CpuWordOff_i;
                    state_d = ST_WRITE_THRU;
                end
            end
            ST_WRITE_THRU: begin
                MemReq_o     = 1'b1;
                MemWr_o      = 1'b1;
                MemWordOff_o = off_q;
                if (MemAck_i) begin
                    CpuReady_o = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_REFILL: begin
                MemReq_o     = 1'b1;
                MemWordOff_o = fc_cnt;
                if (MemAck_i) begin
                    DataWe_o  = 1'b1;
                    FillSel_o = 1'b1;
                    WordSel_o = fc_cnt;
                    fc_inc    = 1'b1;
                    if (fc_tc) begin
                        TagWe_o     = 1'b1;
                        ValidWe_o   = 1'b1;
                        ValidData_o = 1'b1;
                        state_d     = ST_RESUME;
                    end
                end
            end
            ST_RESUME: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (Reset_i) begin
            CpuReady_o   = 1'b0;
            MemReq_o     = 1'b0;
            MemWr_o      = 1'b0;
            MemWordOff_o = '0;
            DataWe_o     = 1'b0;
            WordSel_o    = '0;
            FillSel_o    = 1'b0;
            TagWe_o      = 1'b0;
            ValidWe_o    = 1'b0;
            ValidData_o  = 1'b0;
        end
    end

    // State, latched write offset and statistics registers.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q <= ST_IDLE;
            off_q   <= '0;
            rd_q    <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            miss_q  <= miss_d;
        end
    end

    assign ReadCnt_o = Reset_i ? '0 : rd_q;
    assign MissCnt_o = Reset_i ? '0 : miss_q;

endmodule
